// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// Holds the debug-visible state encoding and the domain release mask helper.
package pll_seq_pkg;

  localparam int NUM_DOMAINS = 7;
  localparam int CNT_W       = 16;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } seq_state_t;

  // Domain i stays in reset while fewer than gap*(i+1) cycles have elapsed in RELEASE.
  function automatic logic [NUM_DOMAINS-1:0] release_mask(
    input logic [CNT_W-1:0] cnt,
    input logic [CNT_W-1:0] gap
  );
    logic [NUM_DOMAINS-1:0] mask;
    mask = '0;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      mask[i] = (cnt < gap * CNT_W'(i + 1));
    end
    return mask;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
// Latency: 2 cycles; no flow control, level signal only.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: pulses pll_rst, qualifies lock, staggers domain resets, retries then faults.
// Latency: lock seen 2 cycles after pll_locked via sync_2ff; all outputs registered; no flow control.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_HOLD     = 16,
  parameter int unsigned LOCK_TIMEOUT = 50000,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned RELEASE_GAP  = 8,
  parameter int unsigned MAX_RETRIES  = 3
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   pll_locked,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] dom_rst,
  output logic                   ready,
  output logic                   fault,
  output logic [3:0]             retry_cnt,
  output logic [2:0]             state
);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] GAP          = CNT_W'(RELEASE_GAP);
  localparam logic [CNT_W-1:0] RELEASE_END  = CNT_W'(RELEASE_GAP * NUM_DOMAINS);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  seq_state_t             state_q, state_nx;
  logic [CNT_W-1:0]       cnt_q, cnt_nx;
  logic [3:0]             retry_nx;
  logic                   lock_s;
  logic                   fail;
  logic                   pll_rst_nx;
  logic [NUM_DOMAINS-1:0] dom_rst_nx;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q + CNT_W'(1);
    retry_nx = retry_cnt;
    fail     = 1'b0;

    unique case (state_q)
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) state_nx = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // Lock arriving on the terminal count still counts as success.
        if (lock_s)                     state_nx = ST_STABLE;
        else if (cnt_q == TIMEOUT_LAST) fail     = 1'b1;
      end
      ST_STABLE: begin
        if (!lock_s)                   state_nx = ST_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_nx = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!lock_s)                   fail     = 1'b1;
        else if (cnt_q == RELEASE_END) state_nx = ST_RUN;
      end
      ST_RUN: begin
        cnt_nx = cnt_q;
        if (!lock_s) state_nx = ST_HOLD;
      end
      ST_FAULT: begin
        cnt_nx = cnt_q;
      end
      default: begin
        state_nx = ST_HOLD;
      end
    endcase

    if (fail) begin
      if (retry_cnt == RETRY_LIMIT) begin
        state_nx = ST_FAULT;
      end else begin
        retry_nx = retry_cnt + 4'd1;
        state_nx = ST_HOLD;
      end
    end

    if (state_nx == ST_RUN && state_q != ST_RUN) retry_nx = '0;
    if (state_nx != state_q) cnt_nx = '0;

    // Outputs are decoded from the next state so they land on the same edge as the transition.
    pll_rst_nx = (state_nx == ST_HOLD) || (state_nx == ST_FAULT);
    unique case (state_nx)
      ST_RUN:     dom_rst_nx = '0;
      ST_RELEASE: dom_rst_nx = release_mask(cnt_nx, GAP);
      default:    dom_rst_nx = '1;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= ST_HOLD;
      cnt_q     <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      dom_rst   <= '1;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state_q   <= state_nx;
      cnt_q     <= cnt_nx;
      retry_cnt <= retry_nx;
      pll_rst   <= pll_rst_nx;
      dom_rst   <= dom_rst_nx;
      ready     <= (state_nx == ST_RUN);
      fault     <= (state_nx == ST_FAULT);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small timing parameters.
// Inputs driven and outputs sampled 1 time unit after each rising refclk edge.
module tb_pll_reset_sequencer;

  localparam logic [2:0] S_HOLD    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_STABLE  = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd4;
  localparam logic [2:0] S_FAULT   = 3'd5;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst;
  logic [6:0] dom_rst;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  int vectors;
  int miscompares;

  pll_reset_sequencer #(
    .RST_HOLD     (4),
    .LOCK_TIMEOUT (32),
    .LOCK_STABLE  (8),
    .RELEASE_GAP  (2),
    .MAX_RETRIES  (2)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .dom_rst    (dom_rst),
    .ready      (ready),
    .fault      (fault),
    .retry_cnt  (retry_cnt),
    .state      (state)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, input string tag);
    int n;
    n = 0;
    while (state !== s && n < max) begin
      tick(1);
      n++;
    end
    check(tag, 32'(state), 32'(s));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, 32'(state), 32'(S_HOLD));
    check({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
    check({tag, "_dom_rst"}, 32'(dom_rst), 32'h7F);
    check({tag, "_ready"}, 32'(ready), 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    check({tag, "_retry"}, 32'(retry_cnt), 32'd0);
  endtask

  // One-cycle reset pulse; returns sampled just after the reset edge with rst low again.
  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  function automatic logic [6:0] dom_exp(input int k);
    logic [6:0] r;
    r = '0;
    for (int i = 0; i < 7; i++) if (k < 2 * (i + 1)) r[i] = 1'b1;
    return r;
  endfunction

  initial begin
    int hi;
    int bad;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    pll_locked  = 1'b0;

    // Reset state
    tick(3);
    check_reset_vals("rst");
    rst = 1'b0;

    // Nominal bring-up: pll_rst pulse width
    hi = 0;
    for (int n = 0; n < 20 && pll_rst === 1'b1; n++) begin
      hi++;
      tick(1);
    end
    check("nom_pll_rst_width", 32'(hi), 32'd4);
    check("nom_wait_state", 32'(state), 32'(S_WAIT));
    tick(6);
    pll_locked = 1'b1;
    tick(2);
    check("nom_sync_latency", 32'(state), 32'(S_WAIT));
    tick(1);
    check("nom_stable_entry", 32'(state), 32'(S_STABLE));
    tick(7);
    check("nom_stable_last", 32'(state), 32'(S_STABLE));
    tick(1);
    check("nom_release_entry", 32'(state), 32'(S_RELEASE));
    check("nom_dom_k0", 32'(dom_rst), 32'h7F);
    bad = 0;
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      if (dom_rst !== dom_exp(k) || ready !== 1'b0) bad++;
    end
    check("nom_dom_stagger", 32'(bad), 32'd0);
    check("nom_dom_k14", 32'(dom_rst), 32'h00);
    check("nom_ready_k14", 32'(ready), 32'd0);
    tick(1);
    check("nom_run_state", 32'(state), 32'(S_RUN));
    check("nom_ready", 32'(ready), 32'd1);
    check("nom_retry", 32'(retry_cnt), 32'd0);
    check("nom_pll_rst_low", 32'(pll_rst), 32'd0);

    // Lock loss in RUN
    pll_locked = 1'b0;
    tick(2);
    check("loss_ready_before", 32'(ready), 32'd1);
    tick(1);
    check("loss_state", 32'(state), 32'(S_HOLD));
    check("loss_dom_rst", 32'(dom_rst), 32'h7F);
    check("loss_ready", 32'(ready), 32'd0);
    check("loss_retry", 32'(retry_cnt), 32'd0);
    hi = 0;
    for (int n = 0; n < 20 && pll_rst === 1'b1; n++) begin
      hi++;
      tick(1);
    end
    check("loss_pll_rst_width", 32'(hi), 32'd4);
    pll_locked = 1'b1;
    wait_state(S_RUN, 40, "loss_relock_run");
    check("loss_relock_retry", 32'(retry_cnt), 32'd0);

    // Glitch while STABLE
    do_reset();
    wait_state(S_STABLE, 20, "glitch_reach_stable");
    tick(4);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(1);
    check("glitch_still_stable", 32'(state), 32'(S_STABLE));
    tick(1);
    check("glitch_back_wait", 32'(state), 32'(S_WAIT));
    check("glitch_retry", 32'(retry_cnt), 32'd0);
    tick(1);
    check("glitch_restable", 32'(state), 32'(S_STABLE));
    tick(7);
    check("glitch_full_count", 32'(state), 32'(S_STABLE));
    tick(1);
    check("glitch_release", 32'(state), 32'(S_RELEASE));

    // Lock never asserts: three timeouts then FAULT
    pll_locked = 1'b0;
    do_reset();
    tick(35);
    check("to1_last_wait", 32'(state), 32'(S_WAIT));
    tick(1);
    check("to1_hold", 32'(state), 32'(S_HOLD));
    check("to1_retry", 32'(retry_cnt), 32'd1);
    check("to1_dom_rst", 32'(dom_rst), 32'h7F);
    tick(35);
    check("to2_last_wait", 32'(state), 32'(S_WAIT));
    tick(1);
    check("to2_retry", 32'(retry_cnt), 32'd2);
    tick(35);
    check("to3_last_wait", 32'(state), 32'(S_WAIT));
    tick(1);
    check("fault_state", 32'(state), 32'(S_FAULT));
    check("fault_flag", 32'(fault), 32'd1);
    check("fault_pll_rst", 32'(pll_rst), 32'd1);
    check("fault_dom_rst", 32'(dom_rst), 32'h7F);
    check("fault_retry", 32'(retry_cnt), 32'd2);
    pll_locked = 1'b1;
    bad = 0;
    repeat (200) begin
      tick(1);
      if (state !== S_FAULT || fault !== 1'b1 || pll_rst !== 1'b1 || retry_cnt !== 4'd2) bad++;
    end
    check("fault_hold_200", 32'(bad), 32'd0);

    // Reset pulse mid-RELEASE, out of FAULT
    do_reset();
    check_reset_vals("fault_exit");
    wait_state(S_RELEASE, 30, "midrel_reach_release");
    tick(7);
    check("midrel_dom_k7", 32'(dom_rst), 32'h78);
    do_reset();
    check_reset_vals("midrel");
    wait_state(S_RUN, 60, "midrel_restart_run");

    // Lock rises on the timeout terminal count
    pll_locked = 1'b0;
    do_reset();
    tick(33);
    pll_locked = 1'b1;
    tick(2);
    check("tie_last_wait", 32'(state), 32'(S_WAIT));
    tick(1);
    check("tie_stable", 32'(state), 32'(S_STABLE));
    check("tie_retry", 32'(retry_cnt), 32'd0);

    // One failed attempt, then RUN clears retry_cnt
    pll_locked = 1'b0;
    do_reset();
    tick(36);
    check("clr_retry_one", 32'(retry_cnt), 32'd1);
    pll_locked = 1'b1;
    wait_state(S_RUN, 50, "clr_reach_run");
    check("clr_retry_zero", 32'(retry_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
